// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: recovers raster position from hsync/vsync and
// verifies line/frame timing before declaring lock.
module vga_sync_monitor #(
  parameter int H_ACTIVE     = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_WIDTH = 96,
  parameter int H_TOTAL      = 800,
  parameter int V_ACTIVE     = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_WIDTH = 2,
  parameter int V_TOTAL      = 525,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] h_pos,
  output logic [9:0] v_pos,
  output logic       de,
  output logic       frame_start,
  output logic       locked,
  output logic [7:0] err_cnt
);

  localparam int LW = $clog2(2*H_TOTAL+1);
  localparam int FW = $clog2(2*V_TOTAL+1);

  localparam logic [9:0] H_MAX = 10'(H_TOTAL-1);
  localparam logic [9:0] V_MAX = 10'(V_TOTAL-1);
  localparam logic [9:0] H_SS  = 10'(H_SYNC_START);
  localparam logic [9:0] V_SS  = 10'(V_SYNC_START);
  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT = 10'(V_ACTIVE);

  localparam logic [LW-1:0] L_TOT  = LW'(H_TOTAL);
  localparam logic [LW-1:0] L_LOSS = LW'(2*H_TOTAL);
  localparam logic [LW-1:0] L_SW   = LW'(H_SYNC_WIDTH);
  localparam logic [FW-1:0] F_TOT  = FW'(V_TOTAL);
  localparam logic [FW-1:0] F_SW   = FW'(V_SYNC_WIDTH);
  localparam logic [3:0]    G_LOCK = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } state_e;

  state_e state_q, state_d;

  logic hs_q, hs_qq, vs_q, vs_qq;
  logic hs_fall, hs_rise, vs_fall, vs_rise;

  logic [9:0]    h_pos_q, h_pos_d;
  logic [9:0]    v_pos_q, v_pos_d;
  logic [LW-1:0] line_len_q, line_len_d;
  logic [LW-1:0] hs_low_q, hs_low_d;
  logic [FW-1:0] vs_lines_q, vs_lines_d;
  logic [FW-1:0] frame_lines_q, frame_lines_d;
  logic          seen_q, seen_d;
  logic [3:0]    good_q, good_d;
  logic [7:0]    err_q, err_d;

  logic h_wrap, clr, viol;
  logic bad_line, bad_hw, bad_to, bad_vw, bad_frame;

  assign hs_fall = hs_qq & ~hs_q;
  assign hs_rise = ~hs_qq & hs_q;
  assign vs_fall = vs_qq & ~vs_q;
  assign vs_rise = ~vs_qq & vs_q;

  assign h_wrap = (h_pos_q == H_MAX);
  assign clr    = (state_q == SEARCH) && vs_fall;

  always_comb begin
    h_pos_d = h_pos_q + 10'd1;
    if (hs_fall) h_pos_d = H_SS;
    else if (h_wrap) h_pos_d = '0;
    v_pos_d = v_pos_q;
    if (vs_fall) v_pos_d = V_SS;
    else if (h_wrap) v_pos_d = (v_pos_q == V_MAX) ? '0 : v_pos_q + 10'd1;
  end

  always_comb begin
    line_len_d = line_len_q;
    if (clr) line_len_d = '0;
    else if (hs_fall) line_len_d = LW'(1);
    else if (line_len_q != L_LOSS) line_len_d = line_len_q + 1'b1;

    hs_low_d = hs_low_q;
    if (clr) hs_low_d = '0;
    else if (hs_fall) hs_low_d = LW'(1);
    else if (!hs_q && hs_low_q != '1) hs_low_d = hs_low_q + 1'b1;

    seen_d = clr ? 1'b0 : (seen_q | hs_fall);

    vs_lines_d = vs_lines_q;
    if (vs_fall) vs_lines_d = FW'(hs_fall);
    else if (hs_fall && !vs_q && vs_lines_q != '1)
      vs_lines_d = vs_lines_q + 1'b1;

    frame_lines_d = frame_lines_q;
    if (vs_fall) frame_lines_d = FW'(hs_fall);
    else if (hs_fall && frame_lines_q != '1)
      frame_lines_d = frame_lines_q + 1'b1;
  end

  // first hsync edge after entering TRACK has no valid history behind it
  assign bad_line  = hs_fall & seen_q & (line_len_q != L_TOT);
  assign bad_hw    = hs_rise & seen_q & (hs_low_q != L_SW);
  assign bad_to    = ~hs_fall & (line_len_q == L_LOSS - LW'(1));
  assign bad_vw    = vs_rise & (vs_lines_q != F_SW);
  assign bad_frame = vs_fall & (frame_lines_q != F_TOT);
  assign viol = bad_line | bad_hw | bad_to | bad_vw | bad_frame;

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = err_q;
    unique case (state_q)
      SEARCH: begin
        if (vs_fall) begin
          state_d = TRACK;
          good_d  = '0;
        end
      end
      TRACK: begin
        if (viol) begin
          state_d = SEARCH;
        end else if (vs_fall) begin
          good_d = good_q + 4'd1;
          if (good_q + 4'd1 == G_LOCK) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (viol) begin
          state_d = SEARCH;
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      hs_q          <= 1'b1;
      hs_qq         <= 1'b1;
      vs_q          <= 1'b1;
      vs_qq         <= 1'b1;
      h_pos_q       <= '0;
      v_pos_q       <= '0;
      line_len_q    <= '0;
      hs_low_q      <= '0;
      vs_lines_q    <= '0;
      frame_lines_q <= '0;
      seen_q        <= 1'b0;
      good_q        <= '0;
      err_q         <= '0;
      state_q       <= SEARCH;
    end else begin
      hs_q          <= hsync;
      hs_qq         <= hs_q;
      vs_q          <= vsync;
      vs_qq         <= vs_q;
      h_pos_q       <= h_pos_d;
      v_pos_q       <= v_pos_d;
      line_len_q    <= line_len_d;
      hs_low_q      <= hs_low_d;
      vs_lines_q    <= vs_lines_d;
      frame_lines_q <= frame_lines_d;
      seen_q        <= seen_d;
      good_q        <= good_d;
      err_q         <= err_d;
      state_q       <= state_d;
    end
  end

  assign h_pos       = h_pos_q;
  assign v_pos       = v_pos_q;
  assign locked      = (state_q == LOCKED);
  assign de          = locked && (h_pos_q < H_ACT) && (v_pos_q < V_ACT);
  assign frame_start = locked && (h_pos_q == '0) && (v_pos_q == '0);
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: directed bench driving a small-raster sync
// generator into vga_sync_monitor and checking lock, position and errors.
module tb_vga_sync_monitor;

  // small raster keeps lock/relock sequences short
  localparam int HA = 5, HSS = 6, HSW = 3, HT = 10;
  localparam int VA = 3, VSS = 4, VSW = 2, VT = 7;
  localparam int FR = HT * VT;

  logic       pclk = 1'b0;
  logic       reset = 1'b1;
  logic       hsync = 1'b1;
  logic       vsync = 1'b1;
  logic [9:0] h_pos, v_pos;
  logic       de, frame_start, locked;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  int gh = 0, gv = 0;
  int h1 = 0, h2 = 0, h3 = 0;
  int v1 = 0, v2 = 0, v3 = 0;
  bit stretch = 0, narrow = 0, kill_hs = 0;
  int vfalls = 0;
  logic vs_prev = 1'b1;

  vga_sync_monitor #(
    .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_WIDTH(HSW), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_WIDTH(VSW), .V_TOTAL(VT),
    .LOCK_FRAMES(2)
  ) dut (
    .pclk(pclk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .h_pos(h_pos), .v_pos(v_pos), .de(de), .frame_start(frame_start),
    .locked(locked), .err_cnt(err_cnt)
  );

  always #5 pclk = ~pclk;

  // one generator cycle: h3/v3 hold the value driven two cycles earlier
  task automatic step();
    @(negedge pclk);
    h3 = h2; v3 = v2; h2 = h1; v2 = v1; h1 = gh; v1 = gv;
    hsync = kill_hs || !(gh >= HSS && gh < HSS + HSW - (narrow ? 1 : 0));
    vsync = !(gv >= VSS && gv < VSS + VSW);
    if (vs_prev && !vsync) vfalls++;
    vs_prev = vsync;
    if (gh == HT - 1) begin
      if (stretch) stretch = 0;
      else begin
        gh = 0;
        narrow = 0;
        gv = (gv == VT - 1) ? 0 : gv + 1;
      end
    end else gh++;
  endtask

  task automatic goto(input int h, input int v);
    for (int n = 0; n < 2 * FR && !(gh == h && gv == v); n++) step();
  endtask

  task automatic wait_lock(input int budget, output bit ok);
    ok = 0;
    for (int n = 0; n < budget; n++) begin
      step();
      if (locked) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    reset = 1'b1;
    repeat (3) step();
    checks += 6;
    if (h_pos !== 10'd0) begin errors++; $display("FAIL rst_h_pos got %0d want 0", h_pos); end
    if (v_pos !== 10'd0) begin errors++; $display("FAIL rst_v_pos got %0d want 0", v_pos); end
    if (de !== 1'b0) begin errors++; $display("FAIL rst_de got %0b want 0", de); end
    if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_fs got %0b want 0", frame_start); end
    if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked got %0b want 0", locked); end
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL rst_err got %0d want 0", err_cnt); end
    reset = 1'b0;
    vfalls = 0;
    wait_lock(5 * FR, ok);
    checks += 5;
    if (ok !== 1'b1) begin errors++; $display("FAIL lock_timeout got %0b want 1", ok); end
    if (vfalls != 3) begin errors++; $display("FAIL lock_vfalls got %0d want 3", vfalls); end
    if (h_pos !== 10'd0) begin errors++; $display("FAIL lock_h_pos got %0d want 0", h_pos); end
    if (v_pos !== 10'(VSS)) begin errors++; $display("FAIL lock_v_pos got %0d want %0d", v_pos, VSS); end
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL lock_err got %0d want 0", err_cnt); end
  endtask

  task automatic test_tracking();
    int fs = 0;
    logic exp_de, exp_fs;
    repeat (2 * FR) begin
      step();
      exp_de = (h3 < HA) && (v3 < VA);
      exp_fs = (h3 == 0) && (v3 == 0);
      checks += 4;
      if (h_pos !== 10'(h3)) begin errors++; $display("FAIL trk_h_pos got %0d want %0d", h_pos, h3); end
      if (v_pos !== 10'(v3)) begin errors++; $display("FAIL trk_v_pos got %0d want %0d", v_pos, v3); end
      if (de !== exp_de) begin errors++; $display("FAIL trk_de got %0b want %0b", de, exp_de); end
      if (frame_start !== exp_fs) begin errors++; $display("FAIL trk_fs got %0b want %0b", frame_start, exp_fs); end
      if (frame_start) fs++;
    end
    checks++;
    if (fs != 2) begin errors++; $display("FAIL trk_fs_count got %0d want 2", fs); end
  endtask

  task automatic test_stretch();
    bit ok;
    goto(0, 1);
    stretch = 1;
    goto(HSS, 2);
    step();
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL str_lock_t0 got %0b want 1", locked); end
    step();
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL str_lock_t1 got %0b want 1", locked); end
    step();
    checks += 2;
    if (locked !== 1'b0) begin errors++; $display("FAIL str_lock_t2 got %0b want 0", locked); end
    if (err_cnt !== 8'd1) begin errors++; $display("FAIL str_err got %0d want 1", err_cnt); end
    vfalls = 0;
    wait_lock(4 * FR, ok);
    checks += 3;
    if (ok !== 1'b1) begin errors++; $display("FAIL str_relock got %0b want 1", ok); end
    if (vfalls != 3) begin errors++; $display("FAIL str_vfalls got %0d want 3", vfalls); end
    if (err_cnt !== 8'd1) begin errors++; $display("FAIL str_err_relock got %0d want 1", err_cnt); end
  endtask

  task automatic test_narrow();
    bit ok;
    goto(0, 1);
    narrow = 1;
    goto(HSS + HSW - 1, 1);
    step();
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL nar_lock_t0 got %0b want 1", locked); end
    step();
    step();
    checks += 2;
    if (locked !== 1'b0) begin errors++; $display("FAIL nar_lock_t2 got %0b want 0", locked); end
    if (err_cnt !== 8'd2) begin errors++; $display("FAIL nar_err got %0d want 2", err_cnt); end
    wait_lock(4 * FR, ok);
    checks += 2;
    if (ok !== 1'b1) begin errors++; $display("FAIL nar_relock got %0b want 1", ok); end
    if (err_cnt !== 8'd2) begin errors++; $display("FAIL nar_err_relock got %0d want 2", err_cnt); end
  endtask

  task automatic test_timeout();
    bit ok;
    goto(0, 1);
    kill_hs = 1;
    repeat (2 * HT) step();
    kill_hs = 0;
    checks += 2;
    if (locked !== 1'b0) begin errors++; $display("FAIL to_locked got %0b want 0", locked); end
    if (err_cnt !== 8'd3) begin errors++; $display("FAIL to_err got %0d want 3", err_cnt); end
    wait_lock(4 * FR, ok);
    checks += 2;
    if (ok !== 1'b1) begin errors++; $display("FAIL to_relock got %0b want 1", ok); end
    if (err_cnt !== 8'd3) begin errors++; $display("FAIL to_err_once got %0d want 3", err_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    goto(2, 1);
    repeat (3) step();
    checks += 2;
    if (de !== 1'b1) begin errors++; $display("FAIL mid_de_pre got %0b want 1", de); end
    if (h_pos !== 10'd2) begin errors++; $display("FAIL mid_h_pre got %0d want 2", h_pos); end
    #1 reset = 1'b1;
    #1;
    checks += 6;
    if (h_pos !== 10'd0) begin errors++; $display("FAIL mid_h_pos got %0d want 0", h_pos); end
    if (v_pos !== 10'd0) begin errors++; $display("FAIL mid_v_pos got %0d want 0", v_pos); end
    if (de !== 1'b0) begin errors++; $display("FAIL mid_de got %0b want 0", de); end
    if (frame_start !== 1'b0) begin errors++; $display("FAIL mid_fs got %0b want 0", frame_start); end
    if (locked !== 1'b0) begin errors++; $display("FAIL mid_locked got %0b want 0", locked); end
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL mid_err got %0d want 0", err_cnt); end
    step();
    reset = 1'b0;
    vfalls = 0;
    wait_lock(4 * FR, ok);
    checks += 2;
    if (ok !== 1'b1) begin errors++; $display("FAIL mid_relock got %0b want 1", ok); end
    if (vfalls != 3) begin errors++; $display("FAIL mid_vfalls got %0d want 3", vfalls); end
  endtask

  task automatic test_saturate();
    bit ok;
    int exp;
    for (int i = 1; i <= 256; i++) begin
      step();
      while (gh != 0) step();
      narrow = 1;
      for (int n = 0; n < 3 * HT && locked; n++) step();
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL sat_drop_%0d got %0b want 0", i, locked); end
      if (i == 1 || i >= 254) begin
        exp = (i > 255) ? 255 : i;
        checks++;
        if (err_cnt !== 8'(exp)) begin errors++; $display("FAIL sat_err_%0d got %0d want %0d", i, err_cnt, exp); end
      end
      if (i < 256) begin
        wait_lock(4 * FR, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL sat_relock_%0d got %0b want 1", i, ok); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_tracking();
    test_stretch();
    test_narrow();
    test_timeout();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
